// File: rtl/truth_table_capture.sv
// truth_table_capture: sweeps {w,x,y,z} through rows 0..15, samples f after SETTLE cycles, stores each row in a 16-entry memory.
// Latency: SETTLE+2 cycles per row, 16*(SETTLE+2) cycles from start accept to done; read data valid 1 cycle after rd_req.
// Backpressure: start is ignored while busy; rd_req is dropped while busy. Optional signature port enabled by TTC_SIGNATURE_EN.
module truth_table_capture #(
  parameter int SETTLE = 4,
  parameter int FW     = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          w,
  output logic          x,
  output logic          y,
  output logic          z,
  input  logic [FW-1:0] f,
  output logic          busy,
  output logic          done,
  output logic [3:0]    row,
  input  logic          rd_req,
  input  logic [3:0]    rd_addr,
  output logic          rd_valid,
  output logic [FW-1:0] rd_data
`ifdef TTC_SIGNATURE_EN
  ,
  output logic [15:0]   sig
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  // Counter is loaded with SETTLE-1 so the stimulus is held exactly SETTLE cycles.
  localparam logic [7:0] LP_CNT_LOAD = 8'(SETTLE - 1);

  state_t        r_state;
  logic [3:0]    r_row;
  logic [3:0]    r_stim;
  logic [7:0]    r_cnt;
  logic          r_busy;
  logic          r_done;
  logic          r_rd_valid;
  logic [FW-1:0] r_rd_data;
  logic [FW-1:0] r_mem [16];

  logic          w_start_acc;
  logic          w_mem_we;

  assign w_start_acc = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_mem_we    = !rst && (r_state == S_SAMPLE);

  // Sweep sequencer: drive a row, hold it SETTLE cycles, sample, advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_row   <= 4'd0;
      r_stim  <= 4'd0;
      r_cnt   <= 8'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_DRIVE;
            r_row   <= 4'd0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        S_DRIVE: begin
          r_stim  <= r_row;
          r_cnt   <= LP_CNT_LOAD;
          r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_cnt == 8'd0) begin
            r_state <= S_SAMPLE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_SAMPLE: begin
          if (r_row == 4'd15) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_row   <= r_row + 4'd1;
            r_state <= S_DRIVE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Result memory: captured on the sample cycle, never cleared so partial sweeps keep older rows.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_row] <= f;
    end
  end

  // Host read port: one-cycle latency, only served while no sweep is running.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else if (rd_req && !r_busy) begin
      r_rd_valid <= 1'b1;
      r_rd_data  <= r_mem[rd_addr];
    end else begin
      r_rd_valid <= 1'b0;
    end
  end

`ifdef TTC_SIGNATURE_EN
  logic [15:0] r_sig;
  logic [15:0] w_f16;

  // Fold f into 16 bits: zero-extend narrow vectors, truncate wide ones.
  if (FW >= 16) begin : g_f_trunc
    assign w_f16 = f[15:0];
  end else begin : g_f_ext
    assign w_f16 = {{(16 - FW){1'b0}}, f};
  end

  // Rotate-xor signature over every sampled row, frozen once the sweep finishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sig <= 16'd0;
    end else if (w_start_acc) begin
      r_sig <= 16'd0;
    end else if (r_state == S_SAMPLE) begin
      r_sig <= {r_sig[14:0], r_sig[15]} ^ w_f16;
    end
  end

  assign sig = r_sig;
`endif

  assign {w, x, y, z} = r_stim;
  assign row          = r_row;
  assign busy         = r_busy;
  assign done         = r_done;
  assign rd_valid     = r_rd_valid;
  assign rd_data      = r_rd_data;

  // Start acceptance only matters to the optional signature; keep it referenced in all builds.
  logic w_unused_ok;
  assign w_unused_ok = w_start_acc;

endmodule

// File: tb/tb_truth_table_capture.sv
// Bench for truth_table_capture: randomized host traffic and f tables checked cycle-by-cycle against a row/time model.
// The model derives row, stimulus, busy/done and read data from the cycle count since start accept.
// Hand-computed literals pin sweep length, captured values and the signature golden value.
module tb_truth_table_capture;
  localparam int SETTLE  = 4;
  localparam int FW      = 10;
  localparam int ROW_CYC = SETTLE + 2;
  localparam int SWEEP   = 16 * ROW_CYC;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          w, x, y, z;
  logic [FW-1:0] f;
  logic          busy, done;
  logic [3:0]    row;
  logic          rd_req = 1'b0;
  logic [3:0]    rd_addr = 4'd0;
  logic          rd_valid;
  logic [FW-1:0] rd_data;
`ifdef TTC_SIGNATURE_EN
  logic [15:0]   sig;
`endif

  int            checks = 0;
  int            errors = 0;
  int            fmode = 0;
  logic [FW-1:0] rand_tab [16];
  logic [FW-1:0] got [16];

  always #5 clk = ~clk;

  truth_table_capture #(.SETTLE(SETTLE), .FW(FW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .w        (w),
    .x        (x),
    .y        (y),
    .z        (z),
    .f        (f),
    .busy     (busy),
    .done     (done),
    .row      (row),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_valid (rd_valid),
    .rd_data  (rd_data)
`ifdef TTC_SIGNATURE_EN
    ,
    .sig      (sig)
`endif
  );

  // Logic under test seen by the DUT.
  assign f = (fmode == 0) ? {{(FW-4){1'b0}}, w, x, y, z} :
             (fmode == 1) ? {{(FW-2){1'b0}},
                             ((!w & z & x) | (z & y) | (w & x)),
                             ((w | y) & (z | x))} :
             rand_tab[{w, x, y, z}];

  // Expected f for a given row number under the current mode.
  function automatic logic [FW-1:0] fval(input int r);
    logic [FW-1:0] v;
    logic bw, bx, by, bz;
    v  = '0;
    bw = (r / 8) % 2 == 1;
    bx = (r / 4) % 2 == 1;
    by = (r / 2) % 2 == 1;
    bz = r % 2 == 1;
    case (fmode)
      0: v = FW'(r);
      1: begin
        v[0] = (bw || by) && (bz || bx);
        v[1] = (!bw && bz && bx) || (bz && by) || (bw && bx);
      end
      default: v = rand_tab[r];
    endcase
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: everything follows from k = cycles since start accept.
  logic          m_ok = 1'b0;
  logic          m_busy, m_done, m_rdv;
  logic [3:0]    m_row, m_stim;
  logic [FW-1:0] m_rdd;
  logic [FW-1:0] m_mem [16];
  logic [15:0]   m_sig;
  int            m_k;

  always @(posedge clk) begin : model
    int r;
    if (rst) begin
      m_ok = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_row = 4'd0; m_stim = 4'd0;
      m_rdv = 1'b0; m_rdd = '0; m_sig = 16'd0; m_k = 0;
    end else if (m_ok) begin
      if (rd_req && !m_busy) begin
        m_rdv = 1'b1;
        m_rdd = m_mem[rd_addr];
      end else begin
        m_rdv = 1'b0;
      end
      if (m_busy) begin
        m_k++;
        m_stim = 4'((m_k - 1) / ROW_CYC);
        if (m_k % ROW_CYC == 0) begin
          r = m_k / ROW_CYC - 1;
          m_mem[r] = fval(r);
          m_sig = {m_sig[14:0], m_sig[15]} ^ 16'(fval(r));
        end
        m_row = (m_k / ROW_CYC > 15) ? 4'd15 : 4'(m_k / ROW_CYC);
        if (m_k == SWEEP) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else if (start) begin
        m_busy = 1'b1; m_done = 1'b0; m_row = 4'd0; m_k = 0; m_sig = 16'd0;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_ok) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("row", 32'(row), 32'(m_row));
      check("stim", 32'({w, x, y, z}), 32'(m_stim));
      check("rd_valid", 32'(rd_valid), 32'(m_rdv));
      check("rd_data", 32'(rd_data), 32'(m_rdd));
`ifdef TTC_SIGNATURE_EN
      check("sig", 32'(sig), 32'(m_sig));
`endif
    end
  end

  task automatic run_sweep(input bit rd_at_start, input int restart_row, input int reset_row,
                           output int n);
    bit did;
    did = 1'b0;
    n = 0;
    @(negedge clk);
    start = 1'b1;
    rd_req = rd_at_start;
    rd_addr = 4'($urandom_range(0, 15));
    @(negedge clk);
    start = 1'b0;
    rd_req = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
`ifdef TTC_SIGNATURE_EN
    check("sig_cleared", 32'(sig), 32'd0);
`endif
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      n++;
      if (done) break;
      start = 1'b0;
      rd_req = 1'($urandom_range(0, 1));
      rd_addr = 4'($urandom_range(0, 15));
      if (!did && restart_row >= 0 && row == 4'(restart_row)) begin
        start = 1'b1;
        did = 1'b1;
      end
      if (!did && reset_row >= 0 && row == 4'(reset_row)) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rd_req = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_row", 32'(row), 32'd0);
        check("rst_stim", 32'({w, x, y, z}), 32'd0);
        return;
      end
    end
    start = 1'b0;
    rd_req = 1'b0;
    if (!done) check("sweep_timeout", 32'd0, 32'd1);
  endtask

  task automatic read_all();
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("rd_valid_b2b", 32'(rd_valid), 32'd1);
        got[i-1] = rd_data;
      end
      if (i < 16) begin
        rd_req = 1'b1;
        rd_addr = 4'(i);
      end else begin
        rd_req = 1'b0;
      end
    end
  endtask

  task automatic random_reads(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rd_req = 1'($urandom_range(0, 1));
      rd_addr = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic new_table();
    for (int i = 0; i < 16; i++) rand_tab[i] = FW'($urandom);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) rand_tab[i] = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_stim", 32'({w, x, y, z}), 32'd0);
    check("idle_rd_valid", 32'(rd_valid), 32'd0);

    // Identity function: captured rows equal their index.
    fmode = 0;
    run_sweep(1'b0, -1, -1, n);
    check("sweep_len_identity", 32'(n), 32'd96);
    check("done_stim_15", 32'({w, x, y, z}), 32'd15);
`ifdef TTC_SIGNATURE_EN
    check("sig_golden", 32'(sig), 32'h08F7);
`endif
    read_all();
    for (int r = 0; r < 16; r++) check("identity_row", 32'(got[r]), 32'(r));

    // Breadboard functions f0/f1, with a read alongside the start.
    fmode = 1;
    run_sweep(1'b1, -1, -1, n);
    check("sweep_len_func", 32'(n), 32'd96);
    read_all();
    check("func_row3", 32'(got[3][1:0]), 32'd3);
    check("func_row4", 32'(got[4][1:0]), 32'd0);
    check("func_row9", 32'(got[9][1:0]), 32'd1);
    check("func_row12", 32'(got[12][1:0]), 32'd3);

    // Start re-asserted at row 5 must not restart the sweep.
    fmode = 0;
    run_sweep(1'b1, 5, -1, n);
    check("sweep_len_restart_ignored", 32'(n), 32'd96);

    // Reset at row 7, then a clean full sweep on a random table.
    fmode = 2;
    new_table();
    run_sweep(1'b1, -1, 7, n);
    random_reads(20);
    run_sweep(1'b1, -1, -1, n);
    check("sweep_len_after_rst", 32'(n), 32'd96);
    read_all();
    for (int r = 0; r < 16; r++) check("rand_row", 32'(got[r]), 32'(rand_tab[r]));

    // A few more random tables with random host traffic.
    for (int s = 0; s < 3; s++) begin
      new_table();
      run_sweep(1'($urandom_range(0, 1)), -1, -1, n);
      check("sweep_len_rand", 32'(n), 32'd96);
      random_reads(30);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_capture.md
Name: truth_table_capture

Overview:
Sequential stimulus/response unit that sits opposite the combinational breadboard logic. It drives the 4-bit input pattern (w,x,y,z) through all 16 rows and samples the 10 function outputs (f0..f9) once they settle. Captured rows go into a 16-entry result memory. A host reads the memory back through a one-outstanding request/valid port. This replaces the hand-timed testbench sweep with synthesizable hardware.

Parameters:
SETTLE, 4, cycles the inputs are held stable before f is sampled (legal range 1..255)
FW, 10, width of the captured function vector (f9..f0)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
start  in  1  begin a sweep; sampled only in IDLE or DONE
w  out  1  stimulus bit 3 (MSB of row index)
x  out  1  stimulus bit 2
y  out  1  stimulus bit 1
z  out  1  stimulus bit 0 (LSB)
f  in  FW  function outputs from the logic under test, f[0]=f0
busy  out  1  high while a sweep is in progress
done  out  1  high from sweep completion until the next start or reset
row  out  4  row currently driven
rd_req  in  1  read request; accepted only when busy=0
rd_addr  in  4  row to read
rd_valid  out  1  one-cycle pulse, data valid
rd_data  out  FW  captured f vector for rd_addr

Behaviour:
- Single clock domain. All outputs are registered. Reset is synchronous and active-high.
- Reset values: w=x=y=z=0, row=0, busy=0, done=0, rd_valid=0, rd_data=0, settle counter=0, state=IDLE. Memory contents are not cleared.
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE: on start=1, go to DRIVE. row=0, busy=1.
- DRIVE (1 cycle):
  - {w,x,y,z} <= row.
  - Settle counter loads SETTLE-1.
  - Next state: SETTLE.
- SETTLE: hold the inputs. Decrement the counter each cycle; go to SAMPLE after the cycle in which the counter is 0, so the inputs are held SETTLE cycles.
- SAMPLE (1 cycle):
  - mem[row] <= f.
  - If row==15: go to DONE, busy=0, done=1.
  - Otherwise: row <= row+1 and go to DRIVE.
- Cycles per row = SETTLE+2. Full sweep = 16*(SETTLE+2) cycles from the start-accept edge to done rising.
- DONE: inputs stay at row 15 (w=x=y=z=1). start=1 clears done, sets row=0, busy=1 and goes to DRIVE.
- start while busy=1: ignored, no restart.
- Row counter is 4 bits; no wrap past 15 because the SAMPLE state terminates the sweep.
- Read port:
  - rd_req with busy=0: rd_data <= mem[rd_addr] and rd_valid=1 on the next cycle (latency 1).
  - rd_req every cycle gives back-to-back reads.
  - rd_req with busy=1: dropped, rd_valid stays 0.
- Simultaneous start and rd_req in IDLE/DONE: the read is served from pre-sweep contents, and the sweep starts the same cycle.
- Reset mid-sweep: returns to IDLE next edge with reset values. Partially written rows keep their new data; unwritten rows keep old data.
- rd_data holds its last value when rd_valid=0.

Optional Feature:
Macro TTC_SIGNATURE_EN.
- When defined: adds output port sig (16 bits).
  - sig clears to 0 on reset and on start accept.
  - In each SAMPLE: sig <= {sig[14:0],sig[15]} ^ {6'b0,f}. This assumes FW=10; wider FW is truncated to 16 bits.
  - sig is stable while done=1, which allows single-compare pass/fail against a golden value.
- When undefined: no sig port and no signature logic. All other behaviour is identical.

Test Plan:
- Reset then idle 5 cycles -> busy=0, done=0, w=x=y=z=0, rd_valid=0.
- SETTLE=4, f tied to {6'b0,w,x,y,z}, pulse start -> done rises exactly 96 cycles after the start-accept edge. Reads of rows 0..15 return 0..15, rd_valid one cycle after each rd_req.
- f driven by a model of f0=(w|y)&(z|x), f1=(!w&z&x)|(z&y)|(w&x), sweep then read all rows:
  - row 3 -> bit0=1, bit1=1
  - row 4 -> bit0=0, bit1=0
  - row 9 -> bit0=1, bit1=0
  - row 12 -> bit0=1, bit1=1
- start re-asserted at row 5 mid-sweep -> ignored, row continues 6..15; rd_req during sweep -> no rd_valid.
- rst asserted while row=7 -> next edge busy=0, row=0, w..z=0; a new start completes a full sweep normally.
- TTC_SIGNATURE_EN defined, f={6'b0,w,x,y,z} -> sig equals the software-computed rotate-xor over values 0..15 at done. Restart -> sig first cleared to 0.
